// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults and helpers for the CDB arbiter and its round-robin picker.
`ifndef CDB_NUM_REQ
`define CDB_NUM_REQ 2
`endif

package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ_DEF = `CDB_NUM_REQ;
  localparam int CDB_TAG_W_DEF   = 5;
  localparam int CDB_DATA_W_DEF  = 32;

  // Requester index visited k steps after the last grant, wrapping at n.
  function automatic int rr_slot(input int lg, input int k, input int n);
    return (lg + k) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: starting one past the last grant, the
// first asserted request wins. Produces a one-hot grant and its binary index.
module cdb_arbiter_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   lg,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Walk lg+1 .. lg+NUM_REQ (mod NUM_REQ) and keep the first hit.
  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = rr_slot(int'(lg), k, NUM_REQ);
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one result producer per cycle in
// round-robin order and registers the winner's result onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ_DEF,
  parameter int TAG_W   = CDB_TAG_W_DEF,
  parameter int DATA_W  = CDB_DATA_W_DEF,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      Clear_flag,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  input  logic [NUM_REQ*DATA_W-1:0] req_jumppc,
  input  logic [NUM_REQ-1:0]        req_jump,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [DATA_W-1:0]         cdb_jumppc,
  output logic                      cdb_jump,
  output logic [IDX_W-1:0]          cdb_src
);

  // Pointer reset value gives requester 0 first priority.
  localparam logic [IDX_W-1:0] LG_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   lg_q, lg_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
  logic [DATA_W-1:0]  cdb_jumppc_q, cdb_jumppc_d;
  logic               cdb_jump_q, cdb_jump_d;
  logic [IDX_W-1:0]   cdb_src_q, cdb_src_d;

  logic               arb_en;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // Grants only when the pipeline advances and no flush or reset is active.
  assign arb_en   = rdy & ~Clear_flag & ~rst;
  assign pick_req = req_valid & {NUM_REQ{arb_en}};

  cdb_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (pick_req),
    .lg  (lg_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_ready = pick_gnt;

  // Next-state: freeze on !rdy, flush on Clear_flag, else load the winner.
  always_comb begin
    lg_d         = lg_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_value_d  = cdb_value_q;
    cdb_jumppc_d = cdb_jumppc_q;
    cdb_jump_d   = cdb_jump_q;
    cdb_src_d    = cdb_src_q;
    if (rdy) begin
      if (Clear_flag) begin
        cdb_valid_d = 1'b0;
        lg_d        = LG_RST;
      end else if (pick_any) begin
        cdb_valid_d  = 1'b1;
        cdb_tag_d    = req_tag[int'(pick_idx)*TAG_W +: TAG_W];
        cdb_value_d  = req_value[int'(pick_idx)*DATA_W +: DATA_W];
        cdb_jumppc_d = req_jumppc[int'(pick_idx)*DATA_W +: DATA_W];
        cdb_jump_d   = req_jump[pick_idx];
        cdb_src_d    = pick_idx;
        lg_d         = pick_idx;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // Pointer and broadcast register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lg_q         <= LG_RST;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_jumppc_q <= '0;
      cdb_jump_q   <= 1'b0;
      cdb_src_q    <= '0;
    end else begin
      lg_q         <= lg_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_value_q  <= cdb_value_d;
      cdb_jumppc_q <= cdb_jumppc_d;
      cdb_jump_q   <= cdb_jump_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_jumppc = cdb_jumppc_q;
  assign cdb_jump   = cdb_jump_q;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 2-requester and a 4-requester instance.
module tb_cdb_arbiter;

  logic clk, rst, rdy, clr;

  // 2-requester instance
  logic [1:0]  rv, rr, jmp;
  logic [9:0]  tag;
  logic [63:0] val, jpc;
  logic        cv, cj;
  logic [4:0]  ct;
  logic [31:0] cval, cjpc;
  logic [0:0]  csrc;

  // 4-requester instance
  logic [3:0]   rv4, rr4, jmp4;
  logic [19:0]  tag4;
  logic [127:0] val4, jpc4;
  logic         cv4, cj4;
  logic [4:0]   ct4;
  logic [31:0]  cval4, cjpc4;
  logic [1:0]   csrc4;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(.NUM_REQ(2), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(clr),
    .req_valid(rv), .req_ready(rr), .req_tag(tag), .req_value(val),
    .req_jumppc(jpc), .req_jump(jmp),
    .cdb_valid(cv), .cdb_tag(ct), .cdb_value(cval), .cdb_jumppc(cjpc),
    .cdb_jump(cj), .cdb_src(csrc)
  );

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(5), .DATA_W(32)) dut4 (
    .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(clr),
    .req_valid(rv4), .req_ready(rr4), .req_tag(tag4), .req_value(val4),
    .req_jumppc(jpc4), .req_jump(jmp4),
    .cdb_valid(cv4), .cdb_tag(ct4), .cdb_value(cval4), .cdb_jumppc(cjpc4),
    .cdb_jump(cj4), .cdb_src(csrc4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    rv = '0; rv4 = '0; jmp = '0; jmp4 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    rv = 2'b11; rv4 = 4'b1111;
    tag = {5'd9, 5'd8}; val = {32'hAA, 32'hBB}; jpc = '0; jmp = 2'b11;
    #1;
    n_tests++;
    if (rr !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", rr); end
    n_tests++;
    if (rr4 !== 4'b0000) begin n_fail++; $display("FAIL reset_ready4: got %b want 0000", rr4); end
    @(posedge clk); #1;
    n_tests++;
    if ({cv, ct, cval, cjpc, cj, csrc} !== '0) begin
      n_fail++;
      $display("FAIL reset_cdb: got v=%b t=%0d val=%h jpc=%h j=%b src=%0d want all 0", cv, ct, cval, cjpc, cj, csrc);
    end
    n_tests++;
    if ({cv4, csrc4} !== 3'b000) begin n_fail++; $display("FAIL reset_cdb4: got v=%b src=%0d want 0/0", cv4, csrc4); end
    rv = '0; rv4 = '0; jmp = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    rv = 2'b01; tag[4:0] = 5'd3; val[31:0] = 32'h11;
    #1;
    n_tests++;
    if (rr !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", rr); end
    @(posedge clk); #1;
    rv = 2'b00;
    n_tests++;
    if ({cv, ct, cval, csrc} !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
      n_fail++; $display("FAIL single_cdb: got v=%b t=%0d val=%h src=%0d want 1/3/11/0", cv, ct, cval, csrc);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({cv, ct} !== {1'b0, 5'd3}) begin n_fail++; $display("FAIL single_idle: got v=%b t=%0d want 0/3", cv, ct); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_r;
    do_reset();
    rv = 2'b11; tag = {5'd2, 5'd1};
    for (int i = 0; i < 4; i++) begin
      exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_tests++;
      if (rr !== exp_r) begin n_fail++; $display("FAIL alt_ready[%0d]: got %b want %b", i, rr, exp_r); end
      @(posedge clk); #1;
      n_tests++;
      if ({cv, ct, csrc} !== {1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, exp_r[1]}) begin
        n_fail++; $display("FAIL alt_cdb[%0d]: got v=%b t=%0d src=%0d want 1/%0d/%0d", i, cv, ct, csrc, (i % 2) + 1, i % 2);
      end
    end
    rv = 2'b00;
  endtask

  task automatic test_wrap4();
    int e;
    do_reset();
    tag4 = {5'd7, 5'd6, 5'd5, 5'd4};
    rv4 = 4'b0100;
    #1;
    n_tests++;
    if (rr4 !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup_ready: got %b want 0100", rr4); end
    @(posedge clk); #1;
    n_tests++;
    if ({cv4, ct4, csrc4} !== {1'b1, 5'd6, 2'd2}) begin
      n_fail++; $display("FAIL wrap_setup_cdb: got v=%b t=%0d src=%0d want 1/6/2", cv4, ct4, csrc4);
    end
    rv4 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      e = (3 + i) % 4;
      #1;
      n_tests++;
      if (rr4 !== 4'(1 << e)) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b want %b", i, rr4, 4'(1 << e)); end
      @(posedge clk); #1;
      n_tests++;
      if ({ct4, csrc4} !== {5'(4 + e), 2'(e)}) begin
        n_fail++; $display("FAIL wrap_cdb[%0d]: got t=%0d src=%0d want %0d/%0d", i, ct4, csrc4, 4 + e, e);
      end
    end
    rv4 = 4'b0000;
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    rv = 2'b10; tag = {5'd7, 5'd5};
    @(posedge clk); #1;
    n_tests++;
    if ({cv, ct, csrc} !== {1'b1, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL freeze_setup: got v=%b t=%0d src=%0d want 1/7/1", cv, ct, csrc);
    end
    rdy = 1'b0; rv = 2'b11; tag = {5'd6, 5'd5};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (rr !== 2'b00) begin n_fail++; $display("FAIL freeze_ready[%0d]: got %b want 00", i, rr); end
      @(posedge clk); #1;
      n_tests++;
      if ({cv, ct, csrc} !== {1'b1, 5'd7, 1'b1}) begin
        n_fail++; $display("FAIL freeze_cdb[%0d]: got v=%b t=%0d src=%0d want 1/7/1", i, cv, ct, csrc);
      end
    end
    rdy = 1'b1;
    #1;
    n_tests++;
    if (rr !== 2'b01) begin n_fail++; $display("FAIL freeze_resume_ready: got %b want 01", rr); end
    @(posedge clk); #1;
    n_tests++;
    if ({cv, ct, csrc} !== {1'b1, 5'd5, 1'b0}) begin
      n_fail++; $display("FAIL freeze_resume_cdb: got v=%b t=%0d src=%0d want 1/5/0", cv, ct, csrc);
    end
    rv = 2'b00;
  endtask

  task automatic test_clear();
    do_reset();
    rv = 2'b11; tag = {5'd2, 5'd1};
    @(posedge clk); #1;
    n_tests++;
    if ({cv, ct} !== {1'b1, 5'd1}) begin n_fail++; $display("FAIL clear_setup: got v=%b t=%0d want 1/1", cv, ct); end
    clr = 1'b1;
    #1;
    n_tests++;
    if (rr !== 2'b00) begin n_fail++; $display("FAIL clear_ready: got %b want 00", rr); end
    @(posedge clk); #1;
    clr = 1'b0;
    n_tests++;
    if ({cv, ct} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL clear_cdb: got v=%b t=%0d want 0/1", cv, ct); end
    #1;
    n_tests++;
    if (rr !== 2'b01) begin n_fail++; $display("FAIL clear_first_grant: got %b want 01", rr); end
    @(posedge clk); #1;
    n_tests++;
    if ({cv, ct, csrc} !== {1'b1, 5'd1, 1'b0}) begin
      n_fail++; $display("FAIL clear_after_cdb: got v=%b t=%0d src=%0d want 1/1/0", cv, ct, csrc);
    end
    rv = 2'b00;
  endtask

  task automatic test_jump();
    do_reset();
    rv = 2'b01; jmp = 2'b01; tag[4:0] = 5'd9; jpc[31:0] = 32'h80; val[31:0] = 32'h44;
    @(posedge clk); #1;
    n_tests++;
    if ({cv, cj, cjpc, ct} !== {1'b1, 1'b1, 32'h80, 5'd9}) begin
      n_fail++; $display("FAIL jump_cdb: got v=%b j=%b jpc=%h t=%0d want 1/1/80/9", cv, cj, cjpc, ct);
    end
    jmp = 2'b00; tag[4:0] = 5'd10; val[31:0] = 32'h22;
    @(posedge clk); #1;
    n_tests++;
    if ({cv, cj, ct, cval} !== {1'b1, 1'b0, 5'd10, 32'h22}) begin
      n_fail++; $display("FAIL nojump_cdb: got v=%b j=%b t=%0d val=%h want 1/0/10/22", cv, cj, ct, cval);
    end
    rv = 2'b00;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    rv = '0; tag = '0; val = '0; jpc = '0; jmp = '0;
    rv4 = '0; tag4 = '0; val4 = '0; jpc4 = '0; jmp4 = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap4();
    test_rdy_freeze();
    test_clear();
    test_jump();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
